// File: rtl/slc3_mem_responder_if.sv
// SRAM-style strobe bus between the SLC-3 control unit (master) and the memory responder (slave).
// Handshake: an access is live only while Mem_CE is low; Mem_OE low requests a read, Mem_WE low a write.
interface slc3_mem_responder_if;
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;

    modport master (
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        input  Data_to_CPU
    );

    modport slave (
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        output Data_to_CPU
    );
endinterface

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3: on-chip word memory plus the 0xFFFF switch/hex I/O port,
// answering active-low SRAM strobes with fixed read/write wait timing.
module slc3_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    slc3_mem_responder_if.slave  bus,
    input  logic [15:0]          Switches,
    output logic [15:0]          HEX_Data,
    output logic                 Busy,
    output logic                 Err,
    output logic [2:0]           state_o
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_VALID = 3'd2,
        WR_WAIT  = 3'd3,
        WR_DONE  = 3'd4
    } state_e;

    localparam int          MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int          CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] RD_INIT = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_INIT = CW'(WRITE_WAIT - 1);
    localparam logic [16:0] DEPTH    = 17'(1) << DEPTH_LOG2;
    localparam logic [15:0] IO_ADDR  = 16'hFFFF;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [15:0]    addr_q;
    logic [15:0]    wdata_q;
    logic           ub_q;
    logic           lb_q;
    logic [15:0]    dout_q;
    logic [15:0]    hex_q;
    logic           err_q;

    logic [15:0]    mem [0:(1 << DEPTH_LOG2) - 1];

    logic           access;
    logic           conflict;
    logic [15:0]    rd_addr;
    logic           rd_ub;
    logic           rd_lb;
    logic [15:0]    rd_word;
    logic [15:0]    rd_data;
    logic           wr_in_mem;
    logic           commit;

    assign access   = !bus.Mem_CE;
    assign conflict = access && !bus.Mem_OE && !bus.Mem_WE;

    // In IDLE the read path looks at the live bus so a single-cycle wait can load data on the latching edge.
    always_comb begin
        rd_addr = addr_q;
        rd_ub   = ub_q;
        rd_lb   = lb_q;
        if (state_q == IDLE) begin
            rd_addr = bus.ADDR;
            rd_ub   = bus.Mem_UB;
            rd_lb   = bus.Mem_LB;
        end
        rd_word = 16'h0000;
        if (rd_addr == IO_ADDR) begin
            rd_word = Switches;
        end else if ({1'b0, rd_addr} < DEPTH) begin
            rd_word = mem[rd_addr[DEPTH_LOG2-1:0]];
        end
        rd_data = {(rd_ub ? 8'h00 : rd_word[15:8]), (rd_lb ? 8'h00 : rd_word[7:0])};
    end

    assign wr_in_mem = ({1'b0, addr_q} < DEPTH) && (addr_q != IO_ADDR);
    assign commit    = !Reset && (state_q == WR_WAIT) && access && !bus.Mem_WE && bus.Mem_OE
                       && (cnt_q == '0);

    always_ff @(posedge Clk) begin
        if (commit && wr_in_mem) begin
            if (!ub_q) mem[addr_q[DEPTH_LOG2-1:0]][15:8] <= wdata_q[15:8];
            if (!lb_q) mem[addr_q[DEPTH_LOG2-1:0]][7:0]  <= wdata_q[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            dout_q  <= 16'h0000;
            hex_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else if (!access) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (conflict) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.Mem_OE) begin
                        addr_q <= bus.ADDR;
                        ub_q   <= bus.Mem_UB;
                        lb_q   <= bus.Mem_LB;
                        if (READ_WAIT <= 1) begin
                            state_q <= RD_VALID;
                            dout_q  <= rd_data;
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= RD_INIT;
                        end
                    end else if (!bus.Mem_WE) begin
                        addr_q  <= bus.ADDR;
                        wdata_q <= bus.Data_from_CPU;
                        ub_q    <= bus.Mem_UB;
                        lb_q    <= bus.Mem_LB;
                        state_q <= WR_WAIT;
                        cnt_q   <= WR_INIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.Mem_OE) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q <= CW'(1)) begin
                        state_q <= RD_VALID;
                        cnt_q   <= '0;
                        dout_q  <= rd_data;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RD_VALID: begin
                    if (bus.Mem_OE) state_q <= IDLE;
                    else            dout_q  <= rd_data;
                end
                // cnt_q counts the WE-low cycles still owed before the commit edge.
                WR_WAIT: begin
                    if (bus.Mem_WE) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        if (addr_q == IO_ADDR) begin
                            if (!ub_q) hex_q[15:8] <= wdata_q[15:8];
                            if (!lb_q) hex_q[7:0]  <= wdata_q[7:0];
                        end
                        state_q <= WR_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WR_DONE: begin
                    if (bus.Mem_WE) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.Data_to_CPU = dout_q;
    assign HEX_Data        = hex_q;
    assign Err             = err_q;
    assign Busy            = (state_q != IDLE);
    assign state_o         = state_q;
endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: reference word model and an expected-read queue.
module tb_slc3_mem_responder;
    localparam int RW = 1;
    localparam int WW = 1;

    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] HEX_Data;
    logic        Busy;
    logic        Err;
    logic [2:0]  state_o;

    slc3_mem_responder_if bus();

    slc3_mem_responder #(.DEPTH_LOG2(10), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (bus),
        .Switches (Switches),
        .HEX_Data (HEX_Data),
        .Busy     (Busy),
        .Err      (Err),
        .state_o  (state_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [0:1023];
    logic [15:0] exp_hex = 16'h0000;

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.Mem_CE = 1'b1;
        bus.Mem_OE = 1'b1;
        bus.Mem_WE = 1'b1;
        bus.Mem_UB = 1'b1;
        bus.Mem_LB = 1'b1;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        if (a == 16'hFFFF)      w = Switches;
        else if (a < 16'd1024)  w = model_mem[a[9:0]];
        else                    w = 16'h0000;
        return {(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])};
    endfunction

    // driver: WE low for we_cycles, then one idle cycle; busy_mid samples Busy after the first edge
    task automatic drive_write(input logic [15:0] a, input logic [15:0] d, input logic ub,
                               input logic lb, input int we_cycles, output logic busy_mid);
        bus.ADDR          = a;
        bus.Data_from_CPU = d;
        bus.Mem_UB        = ub;
        bus.Mem_LB        = lb;
        bus.Mem_CE        = 1'b0;
        bus.Mem_OE        = 1'b1;
        bus.Mem_WE        = 1'b0;
        tick();
        busy_mid = Busy;
        repeat (we_cycles - 1) tick();
        idle_bus();
        tick();
        if (we_cycles >= WW + 1) begin
            if (a == 16'hFFFF) begin
                if (!ub) exp_hex[15:8] = d[15:8];
                if (!lb) exp_hex[7:0]  = d[7:0];
            end else if (a < 16'd1024) begin
                if (!ub) model_mem[a[9:0]][15:8] = d[15:8];
                if (!lb) model_mem[a[9:0]][7:0]  = d[7:0];
            end
        end
    endtask

    // driver + scoreboard: OE low for RW+1 cycles with an address wiggle, expected read popped on output
    task automatic do_read(input logic [15:0] a, input logic ub, input logic lb, input string name);
        logic [15:0] e;
        exp_q.push_back(model_read(a, ub, lb));
        bus.ADDR   = a;
        bus.Mem_UB = ub;
        bus.Mem_LB = lb;
        bus.Mem_CE = 1'b0;
        bus.Mem_OE = 1'b0;
        bus.Mem_WE = 1'b1;
        repeat (RW) tick();
        e = exp_q.pop_front();
        n_vec++;
        if (bus.Data_to_CPU !== e || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s: data=%h busy=%b required data=%h busy=1", name, bus.Data_to_CPU, Busy, e);
        end
        bus.ADDR = ~a;
        tick();
        n_vec++;
        if (bus.Data_to_CPU !== e) begin
            n_err++;
            $display("FAIL %s_held: data=%h required %h", name, bus.Data_to_CPU, e);
        end
        idle_bus();
        tick();
        n_vec++;
        if (bus.Data_to_CPU !== e || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: data=%h busy=%b required data=%h busy=0", name, bus.Data_to_CPU, Busy, e);
        end
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        Switches = 16'h0000;
        bus.ADDR = 16'h0000;
        bus.Data_from_CPU = 16'h0000;
        idle_bus();
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        n_vec++;
        if (bus.Data_to_CPU !== 16'h0000 || HEX_Data !== 16'h0000 || Busy !== 1'b0 || Err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: data=%h hex=%h busy=%b err=%b required 0000 0000 0 0",
                     bus.Data_to_CPU, HEX_Data, Busy, Err);
        end
    endtask

    task automatic test_write_read();
        logic b;
        drive_write(16'h0010, 16'h1234, 1'b0, 1'b0, 2, b);
        n_vec++;
        if (b !== 1'b1) begin
            n_err++;
            $display("FAIL busy_write: busy=%b required 1", b);
        end
        do_read(16'h0010, 1'b0, 1'b0, "read_0010");
    endtask

    task automatic test_short_write();
        logic b;
        drive_write(16'h0020, 16'h7777, 1'b0, 1'b0, 2, b);
        drive_write(16'h0020, 16'hBEEF, 1'b0, 1'b0, 1, b);
        do_read(16'h0020, 1'b0, 1'b0, "short_write");
    endtask

    task automatic test_hex();
        logic b;
        drive_write(16'hFFFF, 16'hA5C3, 1'b0, 1'b0, 2, b);
        n_vec++;
        if (HEX_Data !== 16'hA5C3) begin
            n_err++;
            $display("FAIL hex_write: hex=%h required a5c3", HEX_Data);
        end
        drive_write(16'hFFFF, 16'h1200, 1'b1, 1'b0, 2, b);
        n_vec++;
        if (HEX_Data !== exp_hex) begin
            n_err++;
            $display("FAIL hex_lane: hex=%h required %h", HEX_Data, exp_hex);
        end
        Switches = 16'h0F0F;
        do_read(16'hFFFF, 1'b0, 1'b0, "switches");
    endtask

    task automatic test_lanes();
        logic b;
        drive_write(16'h0030, 16'h0000, 1'b0, 1'b0, 2, b);
        drive_write(16'h0030, 16'hABCD, 1'b0, 1'b1, 2, b);
        do_read(16'h0030, 1'b0, 1'b0, "lane_both");
        do_read(16'h0030, 1'b1, 1'b0, "lane_low");
        do_read(16'h0030, 1'b0, 1'b1, "lane_high");
    endtask

    task automatic test_out_of_range();
        logic b;
        drive_write(16'h0000, 16'h1111, 1'b0, 1'b0, 2, b);
        drive_write(16'h0400, 16'h9999, 1'b0, 1'b0, 2, b);
        do_read(16'h0400, 1'b0, 1'b0, "oor_read");
        do_read(16'h0000, 1'b0, 1'b0, "oor_alias");
    endtask

    task automatic test_err();
        logic b;
        drive_write(16'h0040, 16'h2222, 1'b0, 1'b0, 2, b);
        bus.ADDR          = 16'h0040;
        bus.Data_from_CPU = 16'hDEAD;
        bus.Mem_UB        = 1'b0;
        bus.Mem_LB        = 1'b0;
        bus.Mem_CE        = 1'b0;
        bus.Mem_OE        = 1'b0;
        bus.Mem_WE        = 1'b0;
        tick();
        n_vec++;
        if (Err !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL err_set: err=%b busy=%b required err=1 busy=0", Err, Busy);
        end
        idle_bus();
        repeat (2) tick();
        do_read(16'h0040, 1'b0, 1'b0, "err_mem");
        n_vec++;
        if (Err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b required 1", Err);
        end
    endtask

    task automatic test_reset_mid_write();
        logic b;
        drive_write(16'h0050, 16'h1357, 1'b0, 1'b0, 2, b);
        bus.ADDR          = 16'h0050;
        bus.Data_from_CPU = 16'h5555;
        bus.Mem_UB        = 1'b0;
        bus.Mem_LB        = 1'b0;
        bus.Mem_CE        = 1'b0;
        bus.Mem_OE        = 1'b1;
        bus.Mem_WE        = 1'b0;
        Reset             = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        idle_bus();
        tick();
        exp_hex = 16'h0000;
        n_vec++;
        if (bus.Data_to_CPU !== 16'h0000 || HEX_Data !== 16'h0000 || Busy !== 1'b0 || Err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: data=%h hex=%h busy=%b err=%b required 0000 0000 0 0",
                     bus.Data_to_CPU, HEX_Data, Busy, Err);
        end
        do_read(16'h0050, 1'b0, 1'b0, "reset_mid_mem");
    endtask

    task automatic test_back_to_back();
        logic        b;
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            drive_write(16'h0100 + 16'(i), 16'($urandom_range(0, 65535)), 1'b0, 1'b0, 2, b);
        end
        for (int i = 0; i < 12; i++) begin
            a = 16'h0100 + 16'($urandom_range(0, 15));
            drive_write(a, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(1, 3), b);
            do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_short_write();
        test_hex();
        test_lanes();
        test_out_of_range();
        test_err();
        test_reset_mid_write();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
